// File: rtl/mouse_pos_sync.sv
// mouse_pos_sync: synchroniser and stability filter for mouse position/button; define MOUSE_POS_CLAMP_EN to clamp position to X_MAX/Y_MAX
module mouse_pos_sync #(
    parameter int DATA_WIDTH    = 12,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int X_MAX         = 799,
    parameter int Y_MAX         = 599
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] xpos,
    input  logic [DATA_WIDTH-1:0] ypos,
    input  logic                  left,
    output logic [DATA_WIDTH-1:0] xpos_out,
    output logic [DATA_WIDTH-1:0] ypos_out,
    output logic                  left_out,
    output logic                  pos_update
);
`ifdef MOUSE_POS_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);
    localparam logic [DATA_WIDTH-1:0] XM = DATA_WIDTH'(X_MAX);
    localparam logic [DATA_WIDTH-1:0] YM = DATA_WIDTH'(Y_MAX);
    logic [DATA_WIDTH-1:0] sx [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sy [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sl;
    logic [DATA_WIDTH-1:0] c_x, c_y, cand_x, cand_y;
    logic [CW-1:0] cnt;
    assign left_out = sl[SYNC_STAGES-1];
    // clamp limits apply only to the last sync stage, before candidate comparison
    always_comb begin
        c_x = (CLAMP && sx[SYNC_STAGES-1] > XM) ? XM : sx[SYNC_STAGES-1];
        c_y = (CLAMP && sy[SYNC_STAGES-1] > YM) ? YM : sy[SYNC_STAGES-1];
    end
    // multi-stage synchroniser for position and button
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sx[i] <= '0;
                sy[i] <= '0;
            end
            sl <= '0;
        end else begin
            sx[0] <= xpos;
            sy[0] <= ypos;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sx[i] <= sx[i-1];
                sy[i] <= sy[i-1];
            end
            sl <= {sl[SYNC_STAGES-2:0], left};
        end
    end
    // stability filter: commit a candidate after it stays unchanged long enough, pulse on real change
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_x     <= '0;
            cand_y     <= '0;
            cnt        <= '0;
            xpos_out   <= '0;
            ypos_out   <= '0;
            pos_update <= 1'b0;
        end else begin
            pos_update <= 1'b0;
            if ({c_x, c_y} != {cand_x, cand_y}) begin
                cand_x <= c_x;
                cand_y <= c_y;
                cnt    <= '0;
            end else if (cnt < CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end else if (cnt == CNT_LAST) begin
                cnt        <= CNT_SAT;
                xpos_out   <= cand_x;
                ypos_out   <= cand_y;
                pos_update <= {cand_x, cand_y} != {xpos_out, ypos_out};
            end
        end
    end
endmodule

// File: tb/tb_mouse_pos_sync.sv
// tb_mouse_pos_sync: directed table-driven bench for mouse_pos_sync at default parameters
module tb_mouse_pos_sync;
`ifdef MOUSE_POS_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    typedef struct {
        logic [11:0] x, y;
        logic        l;
        logic [11:0] ex, ey;
        logic        el, epu;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, left = 1'b0;
    logic [11:0] xpos = '0, ypos = '0;
    logic [11:0] xpos_out, ypos_out;
    logic left_out, pos_update;
    int passed = 0, total = 0;
    vec_t vecs[$];

    mouse_pos_sync dut (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .left(left),
        .xpos_out(xpos_out), .ypos_out(ypos_out), .left_out(left_out), .pos_update(pos_update)
    );

    always #5 clk = ~clk;

    task automatic add(input int n, input int x, input int y, input logic l,
                       input int ex, input int ey, input logic el, input logic epu);
        vec_t v;
        v.x = 12'(x); v.y = 12'(y); v.l = l;
        v.ex = 12'(ex); v.ey = 12'(ey); v.el = el; v.epu = epu;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic step(input logic [11:0] x, input logic [11:0] y, input logic l, input logic r);
        xpos = x; ypos = y; left = l; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [11:0] ex, input logic [11:0] ey,
                       input logic el, input logic epu);
        total++;
        if ({xpos_out, ypos_out, left_out, pos_update} === {ex, ey, el, epu}) passed++;
        else $display("FAIL %s[%0d]: got x=%0d y=%0d left=%b upd=%b, want x=%0d y=%0d left=%b upd=%b",
                      name, idx, xpos_out, ypos_out, left_out, pos_update, ex, ey, el, epu);
    endtask

    initial begin
        logic [11:0] cx, cy;
        cx = CLAMP ? 12'd799 : 12'd1000;
        cy = CLAMP ? 12'd599 : 12'd700;
        add(6, 100, 50, 0, 0, 0, 0, 0);
        add(1, 100, 50, 0, 100, 50, 0, 1);
        add(2, 100, 50, 0, 100, 50, 0, 0);
        add(3, 300, 50, 0, 100, 50, 0, 0);
        add(8, 100, 50, 0, 100, 50, 0, 0);
        add(1, 100, 50, 1, 100, 50, 0, 0);
        add(2, 100, 50, 1, 100, 50, 1, 0);
        add(6, 200, 80, 1, 100, 50, 1, 0);
        add(1, 200, 80, 1, 200, 80, 1, 1);
        add(1, 200, 80, 1, 200, 80, 1, 0);
        add(4, 250, 80, 1, 200, 80, 1, 0);
        add(8, 200, 80, 1, 200, 80, 1, 0);
        add(5, 260, 80, 1, 200, 80, 1, 0);
        add(1, 200, 80, 1, 200, 80, 1, 0);
        add(1, 200, 80, 1, 260, 80, 1, 1);
        add(4, 200, 80, 1, 260, 80, 1, 0);
        add(1, 200, 80, 1, 200, 80, 1, 1);
        add(1, 200, 80, 1, 200, 80, 1, 0);

        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("reset", 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].x, vecs[i].y, vecs[i].l, 1'b0);
            chk("vec", i + 1, vecs[i].ex, vecs[i].ey, vecs[i].el, vecs[i].epu);
        end

        for (int e = 1; e <= 3; e++) step(400, 50, 0, 0);
        step(400, 50, 0, 1);
        chk("rst_mid", 4, 0, 0, 0, 0);
        for (int e = 1; e <= 8; e++) begin
            step(400, 50, 0, 0);
            if (e < 7) chk("recommit", e, 0, 0, 0, 0);
            else chk("recommit", e, 400, 50, 0, e == 7);
        end

        step(0, 0, 0, 1);
        chk("zero_rst", 0, 0, 0, 0, 0);
        for (int e = 1; e <= 20; e++) begin
            step(0, 0, 0, 0);
            chk("zero_hold", e, 0, 0, 0, 0);
        end

        for (int e = 1; e <= 8; e++) begin
            step(1000, 700, 0, 0);
            if (e < 7) chk("big", e, 0, 0, 0, 0);
            else chk("big", e, cx, cy, 0, e == 7);
        end
        for (int e = 1; e <= 8; e++) begin
            step(900, 700, 0, 0);
            if (e < 7 || CLAMP) chk("x900", e, cx, cy, 0, 0);
            else chk("x900", e, 900, 700, 0, e == 7);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mouse_pos_sync.md
Name: mouse_pos_sync

Overview:
Parametrised multi-stage synchroniser and stability filter for mouse position and button, placed between the PS/2 mouse controller domain output and the game/draw logic. Each input passes through SYNC_STAGES flop stages to resolve metastability. Position is then accepted only after it stays unchanged for STABLE_CYCLES cycles. A one-cycle update strobe marks every committed position change.

Parameters:
DATA_WIDTH, 12, width of xpos/ypos buses
SYNC_STAGES, 2, synchroniser depth (legal >= 2)
STABLE_CYCLES, 4, consecutive equal samples required before commit (legal >= 1)
X_MAX, 799, upper clamp for x (used only with the optional feature)
Y_MAX, 599, upper clamp for y (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
xpos  in  DATA_WIDTH  raw mouse x position
ypos  in  DATA_WIDTH  raw mouse y position
left  in  1  raw left-button level
xpos_out  out  DATA_WIDTH  filtered, committed x
ypos_out  out  DATA_WIDTH  filtered, committed y
left_out  out  1  synchronised left button
pos_update  out  1  one-cycle pulse when xpos_out/ypos_out change

Behaviour:
- Single clock clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset: all sync stages, the candidate registers (cand_x, cand_y), the counter cnt, xpos_out, ypos_out, left_out and pos_update are set to 0. Reset asserted mid-count abandons the pending candidate; no pulse is generated on the reset edge.
- Sync chain: {xpos, ypos, left} shift one stage per clk. The last stage is s_x, s_y, s_left.
- left_out = s_left. No stability filtering; latency is SYNC_STAGES edges.
- Filter, evaluated each edge with rst low:
  - (s_x, s_y) != (cand_x, cand_y): cand <= s; cnt <= 0; outputs hold.
  - Equal and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - Equal and cnt == STABLE_CYCLES-1: cnt <= STABLE_CYCLES (saturate); outputs <= cand. pos_update = 1 for exactly that cycle, but only if the committed value differs from the previous output.
  - Equal and cnt == STABLE_CYCLES: hold; pos_update = 0.
- Counter width: $clog2(STABLE_CYCLES+1). The counter never wraps.
- Latency: an input applied before edge 1 and held reaches the outputs at edge SYNC_STAGES+STABLE_CYCLES+1. With defaults this is edge 7.
- Glitch rule: any change shorter than STABLE_CYCLES+1 cycles at the last sync stage is discarded. The outputs keep the last committed value.
- pos_update is registered. It is never high for two consecutive cycles unless the position changes and is re-committed, which requires at least STABLE_CYCLES+1 cycles between commits.
- Simultaneous x and y change: handled as one candidate, giving one commit and one pulse.

Optional Feature:
MOUSE_POS_CLAMP_EN
- Defined: the last-stage values are clamped before candidate comparison, x -> min(s_x, X_MAX) and y -> min(s_y, Y_MAX). Comparison and commit use the clamped values, so xpos_out <= X_MAX and ypos_out <= Y_MAX at all times. Inputs that differ only above the clamp produce no new candidate.
- Undefined: no clamping. X_MAX and Y_MAX are ignored, and full DATA_WIDTH values pass through.

Test Plan:
- Reset then xpos=100, ypos=50 held -> xpos_out=100, ypos_out=50 and a single pos_update pulse at edge 7 (defaults); outputs are 0 before that.
- Stable at (100,50), then xpos=300 for 3 cycles, then back to 100 -> no pos_update; outputs stay (100,50).
- left toggles 0->1 -> left_out=1 exactly 2 edges later; no pos_update.
- xpos=400 held, rst pulsed at edge 4 -> all outputs 0 on the reset edge. Re-commit of 400 happens SYNC_STAGES+STABLE_CYCLES+1 edges after rst deasserts, with one pulse.
- Input held at (0,0) after reset -> no pos_update ever, because the committed value equals the reset value.
- With MOUSE_POS_CLAMP_EN, xpos=1000, ypos=700 -> xpos_out=799, ypos_out=599 with one pulse. A following change to xpos=900 gives no pulse. Without the macro, the first case gives 1000, 700.
